dnn_output_checker: RTL and testbench

- Synthesizable receive-side counterpart to the DNN stimulus path. Sits on the DNN output stream (a_out, y_out) and evaluates results in hardware instead of in simulation.
- Slices the stream into training-case windows of CPC cycles and compares actual against ideal outputs over the valid cycles of each window.
- Reports per-case error/mismatch results with a one-cycle valid pulse, and keeps running totals.
- Used for on-FPGA training-accuracy monitoring; results are read by host/debug logic.

---
 rtl/dnn_output_checker.sv | 111 +++++++++++
 tb/tb_dnn_output_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dnn_output_checker.sv
// Purpose: slices the DNN output stream into CPC-cycle cases and scores actual vs ideal lanes.
// Latency: case results and running totals appear one cycle after the last window cycle.
// Backpressure: none; en=0 freezes every register, done freezes the window, clear restarts.
module dnn_output_checker #(
    parameter int OUT_W       = 1,
    parameter int CPC         = 6,
    parameter int FIRST_VALID = 2,
    parameter int MAX_CASES   = 1000,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = $clog2(CPC),
    localparam int MIS_W      = $clog2(CPC * OUT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [OUT_W-1:0] a_out,
    input  logic [OUT_W-1:0] y_out,
    output logic [IDX_W-1:0] cycle_index,
    output logic             case_valid,
    output logic             case_error,
    output logic [MIS_W-1:0] case_mismatches,
    output logic [CNT_W-1:0] num_train,
    output logic [CNT_W-1:0] total_error,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CPC - 1);
    localparam logic [IDX_W:0]   FV_IDX   = (IDX_W + 1)'(FIRST_VALID);
    localparam longint           SAT_VAL  = (longint'(1) << CNT_W) - 1;
    // A MAX_CASES beyond the counter range terminates at the saturation value instead
    localparam logic [CNT_W-1:0] MAX_CNT  = (longint'(MAX_CASES) >= SAT_VAL) ? {CNT_W{1'b1}}
                                                                             : CNT_W'(MAX_CASES);

    function automatic logic [MIS_W-1:0] popcount(input logic [OUT_W-1:0] v);
        logic [MIS_W-1:0] c;
        c = '0;
        for (int i = 0; i < OUT_W; i++) begin
            c = c + MIS_W'(v[i]);
        end
        return c;
    endfunction

    logic             err_acc;
    logic [MIS_W-1:0] mis_acc;

    logic             advance;
    logic             in_window;
    logic             last_cycle;
    logic [MIS_W-1:0] mism;
    logic             err_next;
    logic [MIS_W-1:0] mis_next;
    logic [CNT_W-1:0] num_train_inc;
    logic [CNT_W-1:0] total_error_inc;

    always_comb begin
        advance         = en && !done && !clear;
        in_window       = ({1'b0, cycle_index} >= FV_IDX);
        last_cycle      = (cycle_index == LAST_IDX);
        mism            = in_window ? popcount(a_out ^ y_out) : '0;
        err_next        = err_acc | (mism != '0);
        mis_next        = mis_acc + mism;
        num_train_inc   = (num_train == {CNT_W{1'b1}}) ? num_train : num_train + CNT_W'(1);
        total_error_inc = total_error;
        if (err_next && (total_error != {CNT_W{1'b1}})) begin
            total_error_inc = total_error + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_index     <= '0;
            case_valid      <= 1'b0;
            case_error      <= 1'b0;
            case_mismatches <= '0;
            num_train       <= '0;
            total_error     <= '0;
            done            <= 1'b0;
            err_acc         <= 1'b0;
            mis_acc         <= '0;
        end else if (clear) begin
            // Last case results stay readable across a restart
            cycle_index <= '0;
            case_valid  <= 1'b0;
            num_train   <= '0;
            total_error <= '0;
            done        <= 1'b0;
            err_acc     <= 1'b0;
            mis_acc     <= '0;
        end else begin
            case_valid <= advance && last_cycle;
            if (advance) begin
                if (last_cycle) begin
                    cycle_index     <= '0;
                    case_error      <= err_next;
                    case_mismatches <= mis_next;
                    total_error     <= total_error_inc;
                    num_train       <= num_train_inc;
                    done            <= (num_train_inc == MAX_CNT);
                    err_acc         <= 1'b0;
                    mis_acc         <= '0;
                end else begin
                    cycle_index <= cycle_index + IDX_W'(1);
                    err_acc     <= err_next;
                    mis_acc     <= mis_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_output_checker.sv
// Directed bench for dnn_output_checker: OUT_W=2, CPC=6, FIRST_VALID=2, MAX_CASES=5.
module tb_dnn_output_checker;

    logic        clk;
    logic        reset;
    logic        en;
    logic        clear;
    logic [1:0]  a_out;
    logic [1:0]  y_out;
    logic [2:0]  cycle_index;
    logic        case_valid;
    logic        case_error;
    logic [3:0]  case_mismatches;
    logic [15:0] num_train;
    logic [15:0] total_error;
    logic        done;

    int checks   = 0;
    int failures = 0;

    dnn_output_checker #(
        .OUT_W(2), .CPC(6), .FIRST_VALID(2), .MAX_CASES(5), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .a_out(a_out), .y_out(y_out),
        .cycle_index(cycle_index), .case_valid(case_valid), .case_error(case_error),
        .case_mismatches(case_mismatches), .num_train(num_train),
        .total_error(total_error), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic [1:0] a, input logic [1:0] y);
        a_out = a;
        y_out = y;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(2'b00, 2'b00);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (cycle_index !== 3'd0) begin failures++; $display("FAIL reset_idx actual=%0d expected=0", cycle_index); end
        checks++; if (case_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%0b expected=0", case_valid); end
        checks++; if (case_error !== 1'b0) begin failures++; $display("FAIL reset_err actual=%0b expected=0", case_error); end
        checks++; if (case_mismatches !== 4'd0) begin failures++; $display("FAIL reset_mis actual=%0d expected=0", case_mismatches); end
        checks++; if (num_train !== 16'd0) begin failures++; $display("FAIL reset_num actual=%0d expected=0", num_train); end
        checks++; if (total_error !== 16'd0) begin failures++; $display("FAIL reset_tot actual=%0d expected=0", total_error); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%0b expected=0", done); end
    endtask

    task automatic test_clean_windows();
        int pulses = 0;
        int first = -1;
        int prev = -1;
        int bad_gap = 0;
        en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cyc(2'b10, 2'b10);
            if (case_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
                if (prev >= 0 && (i - prev) != 6) bad_gap++;
                prev = i;
            end
        end
        checks++; if (pulses !== 4) begin failures++; $display("FAIL clean_pulses actual=%0d expected=4", pulses); end
        checks++; if (first !== 5) begin failures++; $display("FAIL clean_first_pulse actual=%0d expected=5", first); end
        checks++; if (bad_gap !== 0) begin failures++; $display("FAIL clean_spacing actual=%0d expected=0", bad_gap); end
        checks++; if (case_error !== 1'b0) begin failures++; $display("FAIL clean_err actual=%0b expected=0", case_error); end
        checks++; if (total_error !== 16'd0) begin failures++; $display("FAIL clean_tot actual=%0d expected=0", total_error); end
        checks++; if (num_train !== 16'd4) begin failures++; $display("FAIL clean_num actual=%0d expected=4", num_train); end
    endtask

    task automatic test_last_cycle_mismatch();
        do_clear();
        for (int c = 0; c < 5; c++) cyc(2'b00, 2'b00);
        checks++; if (num_train !== 16'd0) begin failures++; $display("FAIL last_num_before actual=%0d expected=0", num_train); end
        checks++; if (total_error !== 16'd0) begin failures++; $display("FAIL last_tot_before actual=%0d expected=0", total_error); end
        cyc(2'b01, 2'b00);
        checks++; if (case_valid !== 1'b1) begin failures++; $display("FAIL last_valid actual=%0b expected=1", case_valid); end
        checks++; if (case_error !== 1'b1) begin failures++; $display("FAIL last_err actual=%0b expected=1", case_error); end
        checks++; if (case_mismatches !== 4'd1) begin failures++; $display("FAIL last_mis actual=%0d expected=1", case_mismatches); end
        checks++; if (total_error !== 16'd1) begin failures++; $display("FAIL last_tot actual=%0d expected=1", total_error); end
        checks++; if (num_train !== 16'd1) begin failures++; $display("FAIL last_num actual=%0d expected=1", num_train); end
    endtask

    task automatic test_early_mismatch();
        for (int c = 0; c < 6; c++) begin
            if (c == 1) cyc(2'b11, 2'b00);
            else        cyc(2'b01, 2'b01);
        end
        checks++; if (case_valid !== 1'b1) begin failures++; $display("FAIL early_valid actual=%0b expected=1", case_valid); end
        checks++; if (case_error !== 1'b0) begin failures++; $display("FAIL early_err actual=%0b expected=0", case_error); end
        checks++; if (case_mismatches !== 4'd0) begin failures++; $display("FAIL early_mis actual=%0d expected=0", case_mismatches); end
        checks++; if (total_error !== 16'd1) begin failures++; $display("FAIL early_tot actual=%0d expected=1", total_error); end
        checks++; if (num_train !== 16'd2) begin failures++; $display("FAIL early_num actual=%0d expected=2", num_train); end
    endtask

    task automatic test_two_lanes();
        do_clear();
        for (int c = 0; c < 6; c++) begin
            if (c == 2 || c == 3) cyc(2'b11, 2'b00);
            else                  cyc(2'b00, 2'b00);
        end
        checks++; if (case_mismatches !== 4'd4) begin failures++; $display("FAIL lanes_mis actual=%0d expected=4", case_mismatches); end
        checks++; if (case_error !== 1'b1) begin failures++; $display("FAIL lanes_err actual=%0b expected=1", case_error); end
        checks++; if (num_train !== 16'd1) begin failures++; $display("FAIL lanes_num actual=%0d expected=1", num_train); end
    endtask

    task automatic test_done();
        int pulses_after = 0;
        int idx_moves = 0;
        do_clear();
        for (int i = 0; i < 30; i++) begin
            cyc(2'b00, 2'b00);
            if (i == 28) begin
                checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_early actual=%0b expected=0", done); end
            end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_set actual=%0b expected=1", done); end
        checks++; if (num_train !== 16'd5) begin failures++; $display("FAIL done_num actual=%0d expected=5", num_train); end
        for (int i = 0; i < 12; i++) begin
            cyc(2'b11, 2'b00);
            if (case_valid !== 1'b0) pulses_after++;
            if (cycle_index !== 3'd0) idx_moves++;
        end
        checks++; if (pulses_after !== 0) begin failures++; $display("FAIL done_pulses actual=%0d expected=0", pulses_after); end
        checks++; if (idx_moves !== 0) begin failures++; $display("FAIL done_idx_held actual=%0d expected=0", idx_moves); end
        checks++; if (num_train !== 16'd5) begin failures++; $display("FAIL done_num_hold actual=%0d expected=5", num_train); end
        checks++; if (total_error !== 16'd0) begin failures++; $display("FAIL done_tot_hold actual=%0d expected=0", total_error); end
        do_clear();
        checks++; if (num_train !== 16'd0) begin failures++; $display("FAIL clear_num actual=%0d expected=0", num_train); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL clear_done actual=%0b expected=0", done); end
        cyc(2'b00, 2'b00);
        checks++; if (cycle_index !== 3'd1) begin failures++; $display("FAIL clear_restart_idx actual=%0d expected=1", cycle_index); end
    endtask

    task automatic test_pause_and_reset();
        int early_pulse = 0;
        do_clear();
        for (int c = 0; c < 3; c++) cyc(2'b00, 2'b00);
        en = 1'b0;
        for (int c = 0; c < 3; c++) cyc(2'b11, 2'b00);
        checks++; if (cycle_index !== 3'd3) begin failures++; $display("FAIL pause_idx actual=%0d expected=3", cycle_index); end
        en = 1'b1;
        cyc(2'b00, 2'b00);
        cyc(2'b00, 2'b00);
        if (case_valid === 1'b1) early_pulse++;
        cyc(2'b01, 2'b00);
        checks++; if (early_pulse !== 0) begin failures++; $display("FAIL pause_early_pulse actual=%0d expected=0", early_pulse); end
        checks++; if (case_valid !== 1'b1) begin failures++; $display("FAIL pause_valid actual=%0b expected=1", case_valid); end
        checks++; if (case_mismatches !== 4'd1) begin failures++; $display("FAIL pause_mis actual=%0d expected=1", case_mismatches); end
        checks++; if (case_error !== 1'b1) begin failures++; $display("FAIL pause_err actual=%0b expected=1", case_error); end
        // Second window: mismatch at index 3, then reset at index 4
        for (int c = 0; c < 4; c++) begin
            if (c == 3) cyc(2'b11, 2'b00);
            else        cyc(2'b00, 2'b00);
        end
        checks++; if (cycle_index !== 3'd4) begin failures++; $display("FAIL prereset_idx actual=%0d expected=4", cycle_index); end
        reset = 1'b0;
        #2;
        checks++; if (cycle_index !== 3'd0) begin failures++; $display("FAIL areset_idx actual=%0d expected=0", cycle_index); end
        checks++; if (case_error !== 1'b0) begin failures++; $display("FAIL areset_err actual=%0b expected=0", case_error); end
        checks++; if (case_mismatches !== 4'd0) begin failures++; $display("FAIL areset_mis actual=%0d expected=0", case_mismatches); end
        checks++; if (num_train !== 16'd0) begin failures++; $display("FAIL areset_num actual=%0d expected=0", num_train); end
        checks++; if (total_error !== 16'd0) begin failures++; $display("FAIL areset_tot actual=%0d expected=0", total_error); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) cyc(2'b00, 2'b00);
        checks++; if (case_error !== 1'b0) begin failures++; $display("FAIL postreset_err actual=%0b expected=0", case_error); end
        checks++; if (case_mismatches !== 4'd0) begin failures++; $display("FAIL postreset_mis actual=%0d expected=0", case_mismatches); end
        checks++; if (num_train !== 16'd1) begin failures++; $display("FAIL postreset_num actual=%0d expected=1", num_train); end
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        a_out = 2'b00;
        y_out = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        test_clean_windows();
        test_last_cycle_mismatch();
        test_early_mismatch();
        test_two_lanes();
        test_done();
        test_pause_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
